// File: rtl/sent_pkg.sv
// Shared SENT TX types: FSM states, tick constants, pause modes, CRC4.
// Imported by the interface, tick generator and frame generator.
package sent_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_STATUS,
    S_DATA,
    S_CRC,
    S_PAUSE
  } state_e;

  localparam int unsigned SYNC_TICKS        = 56;
  localparam int unsigned NIBBLE_BASE_TICKS = 12;
  localparam int unsigned MIN_PAUSE_TICKS   = 12;

  localparam logic [1:0] PM_NONE  = 2'b00;
  localparam logic [1:0] PM_FIXED = 2'b01;
  localparam logic [1:0] PM_CONST = 2'b10;
  localparam logic [1:0] PM_RSVD  = 2'b11;

  function automatic logic [3:0] crc4_tab(input logic [3:0] i);
    logic [3:0] r;
    unique case (i)
      4'd0:  r = 4'd0;
      4'd1:  r = 4'd13;
      4'd2:  r = 4'd7;
      4'd3:  r = 4'd10;
      4'd4:  r = 4'd14;
      4'd5:  r = 4'd3;
      4'd6:  r = 4'd9;
      4'd7:  r = 4'd4;
      4'd8:  r = 4'd1;
      4'd9:  r = 4'd12;
      4'd10: r = 4'd6;
      4'd11: r = 4'd11;
      4'd12: r = 4'd15;
      4'd13: r = 4'd2;
      4'd14: r = 4'd8;
      default: r = 4'd5;
    endcase
    return r;
  endfunction

  // Status nibble is not part of the CRC; only the first n data nibbles are.
  function automatic logic [3:0] crc4_calc(
    input logic [31:0] d,
    input logic [2:0]  n
  );
    logic [3:0] c;
    c = 4'd5;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(n)) c = crc4_tab(c) ^ d[4*k +: 4];
    end
    return crc4_tab(c);
  endfunction

endpackage

// File: rtl/sent_tx_frame_gen_if.sv
// Frame request bus between message formatter (master) and SENT TX (slave).
// Carries valid/ready handshake plus status, data nibbles and pause config.
interface sent_tx_frame_gen_if #(
  parameter int MAX_NIBBLES = 6
);
  import sent_pkg::*;

  logic                     frame_valid_i;
  logic                     frame_ready_o;
  logic [3:0]               status_i;
  logic [4*MAX_NIBBLES-1:0] data_i;
  logic [2:0]               num_nibbles_i;
  logic [1:0]               pause_mode_i;
  logic [11:0]              pause_len_i;
  logic [11:0]              frame_len_i;

  modport master (
    output frame_valid_i, status_i, data_i,
    output num_nibbles_i, pause_mode_i,
    output pause_len_i, frame_len_i,
    input  frame_ready_o
  );

  modport slave (
    input  frame_valid_i, status_i, data_i,
    input  num_nibbles_i, pause_mode_i,
    input  pause_len_i, frame_len_i,
    output frame_ready_o
  );

endinterface

// File: rtl/sent_tick_gen.sv
// SENT tick prescaler: one-clk tick_o every TICK_DIV clocks.
// Ports: clk_i, rst_ni, clr_i (sync restart), tick_o (strobe).
module sent_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // tick_o is not gated by clr_i: the frame FSM decides its ready
  // from the tick, and clr_i depends on ready.
  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT frame transmitter: sync, status, data, CRC4 and optional pause pulses.
// Ports: clk_tx, reset_n_tx, frm (slave bus), sent_o line, status outputs.
module sent_tx_frame_gen
  import sent_pkg::*;
#(
  parameter int MAX_NIBBLES = 6,
  parameter int TICK_DIV    = 4,
  parameter int LOW_TICKS   = 5
) (
  input  logic                clk_tx,
  input  logic                reset_n_tx,
  sent_tx_frame_gen_if.slave  frm,
  output logic                sent_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [3:0]          crc_o,
  output logic                cfg_err_o,
  output logic                pause_ovr_o
);

  localparam int DW = 4 * MAX_NIBBLES;
  localparam logic [11:0] SYNC_M1 = 12'(SYNC_TICKS - 1);
  localparam logic [11:0] NIB_M1  = 12'(NIBBLE_BASE_TICKS - 1);
  localparam logic [11:0] MINP    = 12'(MIN_PAUSE_TICKS);
  localparam logic [11:0] LOWT    = 12'(LOW_TICKS);
  localparam logic [2:0]  MAXN    = 3'(MAX_NIBBLES);

  state_e      state_q;
  logic [11:0] tcnt_q;
  logic [11:0] plen_m1_q;
  logic [11:0] elapsed_q;
  logic [2:0]  idx_q;
  logic [3:0]  status_q;
  logic [DW-1:0] data_q;
  logic [2:0]  num_q;
  logic [1:0]  mode_q;
  logic [11:0] pcfg_q;
  logic [11:0] flen_q;
  logic [3:0]  crc_q;
  logic        sent_q;
  logic        busy_q;
  logic        err_q;
  logic        ovr_q;

  logic        tick;
  logic        pulse_end;
  logic        pause_on;
  logic        last_clk;
  logic        accept;
  logic        good;
  logic [2:0]  idx_nxt;
  logic [11:0] e_now;
  logic [11:0] pause_ticks;
  logic        ovr_nxt;
  logic [3:0]  nib [MAX_NIBBLES];

  for (genvar k = 0; k < MAX_NIBBLES; k++) begin : g_nib
    assign nib[k] = data_q[4*k +: 4];
  end

  sent_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk_tx),
    .rst_ni (reset_n_tx),
    .clr_i  (accept),
    .tick_o (tick)
  );

  assign pause_on  = (mode_q == PM_FIXED) ||
                     (mode_q == PM_CONST);
  assign pulse_end = (state_q != S_IDLE) && tick &&
                     (tcnt_q == plen_m1_q);
  assign last_clk  = pulse_end &&
                     ((state_q == S_PAUSE) ||
                      (state_q == S_CRC && !pause_on));

  assign frm.frame_ready_o = (state_q == S_IDLE) || last_clk;
  assign accept = frm.frame_valid_i && frm.frame_ready_o;
  assign good   = (frm.num_nibbles_i != 3'd0) &&
                  (frm.num_nibbles_i <= MAXN);
  assign idx_nxt = idx_q + 3'd1;

  // Pause length, evaluated on the final tick of the CRC pulse,
  // so that tick is included in the elapsed count.
  always_comb begin
    e_now       = (&elapsed_q) ? elapsed_q : elapsed_q + 12'd1;
    ovr_nxt     = 1'b0;
    pause_ticks = MINP;
    if (mode_q == PM_CONST) begin
      if ({1'b0, flen_q} < {1'b0, e_now} + 13'd12) begin
        ovr_nxt = 1'b1;
      end else begin
        pause_ticks = flen_q - e_now;
      end
    end else if (pcfg_q > MINP) begin
      pause_ticks = pcfg_q;
    end
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      plen_m1_q <= '0;
      elapsed_q <= '0;
      idx_q     <= '0;
      status_q  <= '0;
      data_q    <= '0;
      num_q     <= '0;
      mode_q    <= PM_NONE;
      pcfg_q    <= '0;
      flen_q    <= '0;
      crc_q     <= '0;
      sent_q    <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      err_q <= accept && !good;
      if (tick && state_q != S_IDLE && !(&elapsed_q)) begin
        elapsed_q <= elapsed_q + 12'd1;
      end
      if (accept && good) begin
        status_q  <= frm.status_i;
        data_q    <= frm.data_i;
        num_q     <= frm.num_nibbles_i;
        mode_q    <= frm.pause_mode_i;
        pcfg_q    <= frm.pause_len_i;
        flen_q    <= frm.frame_len_i;
        crc_q     <= crc4_calc(32'(frm.data_i),
                               frm.num_nibbles_i);
        state_q   <= S_SYNC;
        tcnt_q    <= '0;
        plen_m1_q <= SYNC_M1;
        elapsed_q <= '0;
        idx_q     <= '0;
        ovr_q     <= 1'b0;
        sent_q    <= 1'b0;
        busy_q    <= 1'b1;
      end else if (pulse_end) begin
        tcnt_q <= '0;
        sent_q <= 1'b0;
        unique case (state_q)
          S_SYNC: begin
            state_q   <= S_STATUS;
            plen_m1_q <= NIB_M1 + {8'd0, status_q};
          end
          S_STATUS: begin
            state_q   <= S_DATA;
            idx_q     <= '0;
            plen_m1_q <= NIB_M1 + {8'd0, nib[0]};
          end
          S_DATA: begin
            if (idx_nxt == num_q) begin
              state_q   <= S_CRC;
              plen_m1_q <= NIB_M1 + {8'd0, crc_q};
            end else begin
              idx_q     <= idx_nxt;
              plen_m1_q <= NIB_M1 + {8'd0, nib[idx_nxt]};
            end
          end
          S_CRC: begin
            if (pause_on) begin
              state_q   <= S_PAUSE;
              plen_m1_q <= pause_ticks - 12'd1;
              ovr_q     <= ovr_nxt;
            end else begin
              state_q <= S_IDLE;
              sent_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            sent_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (tick && state_q != S_IDLE) begin
        tcnt_q <= tcnt_q + 12'd1;
        sent_q <= (tcnt_q + 12'd1) >= LOWT;
      end
    end
  end

  assign sent_o       = sent_q;
  assign busy_o       = busy_q;
  assign frame_done_o = last_clk;
  assign crc_o        = crc_q;
  assign cfg_err_o    = err_q;
  assign pause_ovr_o  = last_clk && ovr_q;

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Directed bench for sent_tx_frame_gen (TICK_DIV=4, LOW_TICKS=5).
// Measures pulse lengths in clk cycles and checks with assertions.
module tb_sent_tx_frame_gen;
  import sent_pkg::*;

  localparam int MAXN = 6;

  logic       clk_tx = 1'b0;
  logic       reset_n_tx;
  logic       sent_o;
  logic       busy_o;
  logic       frame_done_o;
  logic [3:0] crc_o;
  logic       cfg_err_o;
  logic       pause_ovr_o;

  always #5 clk_tx = ~clk_tx;

  sent_tx_frame_gen_if #(.MAX_NIBBLES(MAXN)) frm ();

  sent_tx_frame_gen #(
    .MAX_NIBBLES (MAXN),
    .TICK_DIV    (4),
    .LOW_TICKS   (5)
  ) u_dut (
    .clk_tx       (clk_tx),
    .reset_n_tx   (reset_n_tx),
    .frm          (frm),
    .sent_o       (sent_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .crc_o        (crc_o),
    .cfg_err_o    (cfg_err_o),
    .pause_ovr_o  (pause_ovr_o)
  );

  int nchk = 0;
  int nerr = 0;

  int pl [16];
  int np, lowbad, first, done_rel, crc_s;
  bit ovr_s, rdy_s, busy_drop, tout;

  int expA [6] = '{224, 48, 52, 56, 60, 48};

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(
    input logic [3:0]  st,
    input logic [23:0] d,
    input logic [2:0]  n,
    input logic [1:0]  m,
    input logic [11:0] plen,
    input logic [11:0] flen
  );
    @(negedge clk_tx);
    frm.status_i      = st;
    frm.data_i        = d;
    frm.num_nibbles_i = n;
    frm.pause_mode_i  = m;
    frm.pause_len_i   = plen;
    frm.frame_len_i   = flen;
    frm.frame_valid_i = 1'b1;
    @(posedge clk_tx);
  endtask

  // Cycle 1 is the first negedge after the accepting posedge.
  task automatic capture(input bit drop);
    int cyc, last, lowrun;
    bit prev, s, done;
    cyc = 0; last = 0; lowrun = 0;
    prev = 1'b1; done = 1'b0;
    np = 0; lowbad = 0; first = -1; done_rel = -1;
    crc_s = -1; ovr_s = 0; rdy_s = 0; busy_drop = 0;
    while (!done && cyc < 6000) begin
      @(negedge clk_tx);
      cyc++;
      if (drop && cyc == 1) frm.frame_valid_i = 1'b0;
      if (cyc == 1) crc_s = int'(crc_o);
      s = sent_o;
      if (!s && prev) begin
        if (first < 0) first = cyc;
        else if (np < 16) begin
          pl[np] = cyc - last;
          np++;
        end
        last = cyc;
        lowrun = 0;
      end
      if (!s) lowrun++;
      if (s && !prev && lowrun != 20) lowbad++;
      if (!busy_o) busy_drop = 1;
      if (frame_done_o) begin
        if (np < 16) begin
          pl[np] = cyc - last + 1;
          np++;
        end
        done_rel = cyc - first + 1;
        ovr_s = pause_ovr_o;
        rdy_s = frm.frame_ready_o;
        done = 1;
      end
      prev = s;
    end
    tout = !done;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk_tx);
    chk({tag, ".idle_busy"}, int'(busy_o), 0);
    chk({tag, ".idle_sent"}, int'(sent_o), 1);
    chk({tag, ".idle_rdy"}, int'(frm.frame_ready_o), 1);
  endtask

  initial begin
    reset_n_tx        = 1'b0;
    frm.frame_valid_i = 1'b0;
    frm.status_i      = '0;
    frm.data_i        = '0;
    frm.num_nibbles_i = '0;
    frm.pause_mode_i  = '0;
    frm.pause_len_i   = '0;
    frm.frame_len_i   = '0;
    repeat (3) @(negedge clk_tx);
    reset_n_tx = 1'b1;
    @(negedge clk_tx);
    chk("rst.sent", int'(sent_o), 1);
    chk("rst.rdy", int'(frm.frame_ready_o), 1);
    chk("rst.busy", int'(busy_o), 0);
    chk("rst.done", int'(frame_done_o), 0);
    chk("rst.crc", int'(crc_o), 0);
    chk("rst.err", int'(cfg_err_o), 0);
    chk("rst.ovr", int'(pause_ovr_o), 0);

    // Frame A: data 1,2,3, no pause
    send(4'h0, 24'h000321, 3'd3, PM_NONE, 12'd0, 12'd0);
    capture(1'b1);
    chk("A.tout", int'(tout), 0);
    chk("A.first", first, 1);
    chk("A.crc", crc_s, 0);
    chk("A.np", np, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("A.p%0d", i), pl[i], expA[i]);
    chk("A.low", lowbad, 0);
    chk("A.len", done_rel, 488);
    chk("A.ovr", int'(ovr_s), 0);
    idle_chk("A");

    // Six zero nibbles, no pause: CRC 5, 157 ticks
    send(4'h0, 24'h000000, 3'd6, PM_NONE, 12'd0, 12'd0);
    capture(1'b1);
    chk("Z.tout", int'(tout), 0);
    chk("Z.crc", crc_s, 5);
    chk("Z.np", np, 9);
    chk("Z.pcrc", pl[8], 68);
    chk("Z.len", done_rel, 628);
    chk("Z.low", lowbad, 0);

    // Six zero nibbles, constant length 300: pause 143 ticks
    send(4'h0, 24'h000000, 3'd6, PM_CONST, 12'd0, 12'd300);
    capture(1'b1);
    chk("ZC.tout", int'(tout), 0);
    chk("ZC.np", np, 10);
    chk("ZC.pause", pl[9], 572);
    chk("ZC.len", done_rel, 1200);
    chk("ZC.ovr", int'(ovr_s), 0);

    // Six 0xF nibbles, constant length 200: overrun
    send(4'h0, 24'hFFFFFF, 3'd6, PM_CONST, 12'd0, 12'd200);
    capture(1'b1);
    chk("FC.tout", int'(tout), 0);
    chk("FC.crc", crc_s, 10);
    chk("FC.np", np, 10);
    chk("FC.pcrc", pl[8], 88);
    chk("FC.pause", pl[9], 48);
    chk("FC.len", done_rel, 1056);
    chk("FC.ovr", int'(ovr_s), 1);
    chk("FC.low", lowbad, 0);
    @(negedge clk_tx);
    chk("FC.ovr_off", int'(pause_ovr_o), 0);

    // Fixed pause of 5 is raised to 12 ticks; status 3
    send(4'h3, 24'h000321, 3'd3, PM_FIXED, 12'd5, 12'd0);
    capture(1'b1);
    chk("FP.tout", int'(tout), 0);
    chk("FP.stat", pl[1], 60);
    chk("FP.pause", pl[6], 48);
    chk("FP.len", done_rel, 548);

    // Back-to-back: valid held across two frames
    send(4'h0, 24'h000321, 3'd3, PM_NONE, 12'd0, 12'd0);
    capture(1'b0);
    chk("BB1.tout", int'(tout), 0);
    chk("BB1.rdy", int'(rdy_s), 1);
    chk("BB1.busy", int'(busy_drop), 0);
    capture(1'b1);
    chk("BB2.tout", int'(tout), 0);
    chk("BB2.first", first, 1);
    chk("BB2.busy", int'(busy_drop), 0);
    chk("BB2.len", done_rel, 488);
    idle_chk("BB");

    // Bad nibble counts
    send(4'h0, 24'h000321, 3'd0, PM_NONE, 12'd0, 12'd0);
    @(negedge clk_tx);
    frm.frame_valid_i = 1'b0;
    chk("E0.err", int'(cfg_err_o), 1);
    chk("E0.sent", int'(sent_o), 1);
    chk("E0.busy", int'(busy_o), 0);
    chk("E0.rdy", int'(frm.frame_ready_o), 1);
    @(negedge clk_tx);
    chk("E0.err_off", int'(cfg_err_o), 0);
    chk("E0.sent2", int'(sent_o), 1);
    send(4'h0, 24'h000321, 3'd7, PM_NONE, 12'd0, 12'd0);
    @(negedge clk_tx);
    frm.frame_valid_i = 1'b0;
    chk("E7.err", int'(cfg_err_o), 1);
    chk("E7.busy", int'(busy_o), 0);

    // Reset during the low phase of data nibble 0
    send(4'h0, 24'hFFFFFF, 3'd6, PM_NONE, 12'd0, 12'd0);
    @(negedge clk_tx);
    frm.frame_valid_i = 1'b0;
    repeat (279) @(negedge clk_tx);
    chk("R.pre_sent", int'(sent_o), 0);
    chk("R.pre_crc", int'(crc_o), 10);
    #1 reset_n_tx = 1'b0;
    #1;
    chk("R.sent", int'(sent_o), 1);
    chk("R.busy", int'(busy_o), 0);
    chk("R.rdy", int'(frm.frame_ready_o), 1);
    chk("R.done", int'(frame_done_o), 0);
    chk("R.crc", int'(crc_o), 0);
    chk("R.err", int'(cfg_err_o), 0);
    chk("R.ovr", int'(pause_ovr_o), 0);
    @(negedge clk_tx);
    reset_n_tx = 1'b1;
    send(4'h0, 24'h000000, 3'd6, PM_NONE, 12'd0, 12'd0);
    capture(1'b1);
    chk("R2.tout", int'(tout), 0);
    chk("R2.first", first, 1);
    chk("R2.crc", crc_s, 5);
    chk("R2.len", done_rel, 628);
    idle_chk("R2");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
